image_fetch_ctrl: RTL and testbench

- Sequences the external image memory stream for one frame at a time.
- Drives the memory's Lock enable, tracks issued reads and the 1-cycle read latency, and buffers returned bytes in a small FIFO.
- Presents pixels downstream on a valid/ready interface tagged with row/column and end-of-frame.
- Sits between the external memory model and the first image-processing stage.

---
 rtl/img_ctrl_pkg.sv | 19 +
 rtl/image_fetch_ctrl_if.sv | 28 ++
 rtl/image_fetch_ctrl_pix_fifo.sv | 53 +++++
 rtl/image_fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_image_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/img_ctrl_pkg.sv
// Shared types and defaults for the image fetch controller.
package img_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int IMG_W_DEF      = 256;
  localparam int IMG_H_DEF      = 256;
  localparam int IMG_PIXELS_DEF = IMG_W_DEF * IMG_H_DEF;

  // Index width for a 0..n-1 counter, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_fetch_ctrl_if.sv
// Downstream pixel stream: valid/ready with row/column tags and end-of-frame.
interface image_fetch_ctrl_if
  import img_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
);
  localparam int RW = idx_w(IMG_H);
  localparam int CW = idx_w(IMG_W);

  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [RW-1:0] pix_row;
  logic [CW-1:0] pix_col;
  logic          pix_last;

  modport master (
    output pix_data, pix_valid, pix_row, pix_col, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_row, pix_col, pix_last,
    output pix_ready
  );

endinterface

// File: rtl/image_fetch_ctrl_pix_fifo.sv
// Small synchronous FIFO holding returned bytes plus the end-of-frame bit.
// Storage is cleared on reset so the idle output reads as zero.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 9
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              din_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              dout_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO may still accept.
  assign push_ok = push_i && (!full || pop_ok);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/image_fetch_ctrl.sv
// Frame fetch controller: issues IMG_W*IMG_H reads via Lock, buffers the
// returned bytes and streams them out tagged with row/column/last.
// Optional: define FRAME_CHECKSUM_EN to add a 16-bit per-frame byte sum output.
module image_fetch_ctrl
  import img_ctrl_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       Lock,
  input  logic [7:0] dina,
  image_fetch_ctrl_if.master pix
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  localparam int PIX = IMG_W * IMG_H;
  localparam int IW  = $clog2(PIX + 1);
  localparam int RW  = idx_w(IMG_H);
  localparam int CW  = idx_w(IMG_W);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  localparam logic [IW-1:0] PIX_L  = IW'(PIX);
  localparam logic [IW-1:0] PIX_M1 = IW'(PIX - 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  issued_q;
  logic           inflight_q;
  logic           done_q, done_d;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  logic           lock_en, room, xfer, fifo_empty;
  logic [FCW-1:0] fifo_cnt;
  logic [FCW:0]   occ;
  logic [8:0]     fifo_dout;

  // Outstanding bytes = buffered + the one still coming back from memory.
  assign occ  = {1'b0, fifo_cnt} + {{FCW{1'b0}}, inflight_q};
  assign room = occ < (FCW+1)'(FIFO_DEPTH);
  assign xfer = pix.pix_valid && pix.pix_ready;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign Lock = lock_en;

  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_data  = fifo_dout[7:0];
  assign pix.pix_last  = !fifo_empty && fifo_dout[8];
  assign pix.pix_row   = row_q;
  assign pix.pix_col   = col_q;

  pix_fifo #(.DEPTH(FIFO_DEPTH), .DW(9)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (inflight_q),
    // The byte returning while issued already equals PIX is the final one.
    .din_i   ({inflight_q && (issued_q == PIX_L), dina}),
    .pop_i   (xfer),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // State and done-pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next state, Lock throttle and end-of-frame detection.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    lock_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        lock_en = room && (issued_q < PIX_L);
        if (lock_en && (issued_q == PIX_M1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (xfer && pix.pix_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read issue counter and the one-cycle memory latency tracker.
  always_ff @(posedge CLK) begin
    if (RST) begin
      issued_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= lock_en;
      if (state_q == IDLE && start) issued_q <= '0;
      else if (lock_en)             issued_q <= issued_q + IW'(1);
    end
  end

  // Row/column of the pixel at the FIFO head; cleared after the last one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q <= '0;
      col_q <= '0;
    end else if (xfer) begin
      if (pix.pix_last) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_q == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] csum_q;
  assign checksum = csum_q;

  // Running byte sum of the frame; holds after done until the next start.
  always_ff @(posedge CLK) begin
    if (RST)                        csum_q <= '0;
    else if (state_q == IDLE && start) csum_q <= '0;
    else if (xfer)                  csum_q <= csum_q + {8'd0, pix.pix_data};
  end
`endif

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Self-checking bench: directed 4x2 frames plus a random-backpressure 16x16 frame.
module tb_image_fetch_ctrl;
  localparam int AW = 4, AH = 2, AP = AW * AH;
  localparam int BW = 16, BH = 16, BP = BW * BH;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic       startA, busyA, doneA, LockA;
  logic       startB, busyB, doneB, LockB;
  logic [7:0] dinaA, dinaB;
  logic [7:0] memA [256];
  logic [7:0] memB [256];
  int         idxA, idxB;

  image_fetch_ctrl_if #(.IMG_W(AW), .IMG_H(AH)) pa ();
  image_fetch_ctrl_if #(.IMG_W(BW), .IMG_H(BH)) pb ();

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] csA, csB;
`endif

  image_fetch_ctrl #(.IMG_W(AW), .IMG_H(AH), .FIFO_DEPTH(DEPTH)) dutA (
    .CLK(CLK), .RST(RST), .start(startA), .busy(busyA), .done(doneA),
    .Lock(LockA), .dina(dinaA), .pix(pa.master)
`ifdef FRAME_CHECKSUM_EN
    , .checksum(csA)
`endif
  );

  image_fetch_ctrl #(.IMG_W(BW), .IMG_H(BH), .FIFO_DEPTH(DEPTH)) dutB (
    .CLK(CLK), .RST(RST), .start(startB), .busy(busyB), .done(doneB),
    .Lock(LockB), .dina(dinaB), .pix(pb.master)
`ifdef FRAME_CHECKSUM_EN
    , .checksum(csB)
`endif
  );

  // Memory models: one byte per Lock cycle, data one cycle later.
  always @(posedge CLK) begin
    if (RST) begin
      idxA <= 0; dinaA <= 8'd0;
    end else if (LockA) begin
      dinaA <= memA[idxA[7:0]]; idxA <= idxA + 1;
    end
  end
  always @(posedge CLK) begin
    if (RST) begin
      idxB <= 0; dinaB <= 8'd0;
    end else if (LockB) begin
      dinaB <= memB[idxB[7:0]]; idxB <= idxB + 1;
    end
  end

  int checks = 0, fails = 0;
  // reference state for A
  int kA = 0, baseA = 0, lockA = 0, ndoneA = 0;
  logic lastprevA = 0, prevLockA = 0, holdA = 0, hlA;
  logic [7:0] hdA;
  logic [31:0] hrA, hcA;
  // reference state for B
  int kB = 0, lockB = 0, ndoneB = 0;
  logic lastprevB = 0, prevLockB = 0;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0] sumA = 0;
  logic clrA = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic stepA(input logic rdy, input logic st);
    logic [7:0] e;
    pa.pix_ready = rdy; startA = st;
    if (holdA) begin
      check("holdA_valid", pa.pix_valid, 1);
      check("holdA_data", pa.pix_data, hdA);
      check("holdA_row", pa.pix_row, hrA);
      check("holdA_col", pa.pix_col, hcA);
      check("holdA_last", pa.pix_last, hlA);
    end
    check("doneA_pulse", doneA, lastprevA);
    check("fifoA_bound", int'(dutA.u_fifo.cnt_q) <= DEPTH, 1);
    if (LockA) begin
      check("throttleA", (int'(dutA.u_fifo.cnt_q) + int'(prevLockA)) < DEPTH, 1);
      lockA++;
    end
`ifdef FRAME_CHECKSUM_EN
    if (clrA) check("csA_clear", csA, 0);
    if (doneA) check("csA_done", csA, {16'd0, sumA[15:0]});
    clrA = 0;
    if (st && !busyA) begin sumA = 0; clrA = 1; end
`endif
    if (doneA) ndoneA++;
    lastprevA = 0;
    if (pa.pix_valid && rdy) begin
      e = memA[8'(baseA + kA)];
      check("xferA_extra", kA < AP, 1);
      check("xferA_data", pa.pix_data, e);
      check("xferA_row", pa.pix_row, kA / AW);
      check("xferA_col", pa.pix_col, kA % AW);
      check("xferA_last", pa.pix_last, kA == AP - 1);
`ifdef FRAME_CHECKSUM_EN
      sumA += e;
`endif
      lastprevA = (kA == AP - 1);
      kA++;
    end
    holdA = pa.pix_valid && !rdy;
    hdA = pa.pix_data; hrA = pa.pix_row; hcA = pa.pix_col; hlA = pa.pix_last;
    prevLockA = LockA;
    @(negedge CLK);
  endtask

  task automatic stepB(input logic rdy, input logic st);
    pb.pix_ready = rdy; startB = st;
    check("doneB_pulse", doneB, lastprevB);
    check("fifoB_bound", int'(dutB.u_fifo.cnt_q) <= DEPTH, 1);
    if (LockB) begin
      check("throttleB", (int'(dutB.u_fifo.cnt_q) + int'(prevLockB)) < DEPTH, 1);
      lockB++;
    end
    if (doneB) ndoneB++;
    lastprevB = 0;
    if (pb.pix_valid && rdy) begin
      check("xferB_extra", kB < BP, 1);
      check("xferB_data", pb.pix_data, memB[kB[7:0]]);
      check("xferB_row", pb.pix_row, kB / BW);
      check("xferB_col", pb.pix_col, kB % BW);
      check("xferB_last", pb.pix_last, kB == BP - 1);
      lastprevB = (kB == BP - 1);
      kB++;
    end
    prevLockB = LockB;
    @(negedge CLK);
  endtask

  // Runs A until done with ready at pct% duty; optionally pulses start while busy.
  task automatic runA(input int pct, input bit st_busy);
    for (int i = 0; i < 300 && ndoneA == 0; i++)
      stepA($urandom_range(0, 99) < pct, st_busy && busyA);
  endtask

  task automatic endFrameA(input string tag);
    check({tag, "_done_cnt"}, ndoneA, 1);
    check({tag, "_xfers"}, kA, AP);
    check({tag, "_locks"}, lockA, AP);
    check({tag, "_busy"}, busyA, 0);
    baseA += AP; kA = 0; lockA = 0; ndoneA = 0;
  endtask

  initial begin
    RST = 1'b1; startA = 0; startB = 0; pa.pix_ready = 0; pb.pix_ready = 0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 8'(i);
      memB[i] = 8'($urandom_range(0, 255));
    end
    @(negedge CLK); @(negedge CLK);
    // reset state
    check("rst_busy", busyA, 0);
    check("rst_done", doneA, 0);
    check("rst_lock", LockA, 0);
    check("rst_valid", pa.pix_valid, 0);
    check("rst_last", pa.pix_last, 0);
    check("rst_row", pa.pix_row, 0);
    check("rst_col", pa.pix_col, 0);
    check("rst_data", pa.pix_data, 0);
`ifdef FRAME_CHECKSUM_EN
    check("rst_cs", csA, 0);
`endif
    RST = 1'b0;
    @(negedge CLK);

    // 1: free-flowing 4x2 frame, latency checks
    stepA(1, 1);
    check("t1_lock_lat", LockA, 1);
    check("t1_busy", busyA, 1);
    stepA(1, 0);
    check("t1_valid_early", pa.pix_valid, 0);
    stepA(1, 0);
    check("t1_valid_lat", pa.pix_valid, 1);
    check("t1_first", pa.pix_data, 0);
    runA(100, 0);
    endFrameA("t1");

    // 2: downstream stalls, Lock must throttle at FIFO_DEPTH outstanding
    stepA(0, 1);
    for (int i = 0; i < 12; i++) stepA(0, 0);
    check("t2_lock_off", LockA, 0);
    check("t2_locks", lockA, DEPTH);
    check("t2_fifo_full", dutA.u_fifo.cnt_q, DEPTH);
    check("t2_valid", pa.pix_valid, 1);
    check("t2_head", pa.pix_data, memA[8'(baseA)]);
    runA(100, 0);
    endFrameA("t2");

    // 4: start pulses during FETCH/DRAIN are ignored
    stepA(1, 1);
    runA(50, 1);
    endFrameA("t4");
    for (int i = 0; i < 5; i++) stepA(0, 0);
    check("t4_no_restart_lock", lockA, 0);
    check("t4_no_restart_busy", busyA, 0);

    // 5: reset mid-FETCH
    stepA(1, 1); stepA(1, 0); stepA(1, 0);
    RST = 1'b1; startA = 0;
    @(negedge CLK);
    check("t5_lock", LockA, 0);
    check("t5_busy", busyA, 0);
    check("t5_valid", pa.pix_valid, 0);
    check("t5_row", pa.pix_row, 0);
    check("t5_col", pa.pix_col, 0);
    check("t5_data", pa.pix_data, 0);
    RST = 1'b0;
    baseA = 0; kA = 0; lockA = 0; ndoneA = 0;
    lastprevA = 0; prevLockA = 0; holdA = 0;
    @(negedge CLK);

    // all-0xFF frame (checksum 8*0xFF), then a clean follow-on frame
    for (int i = 0; i < AP; i++) memA[i] = 8'hFF;
    stepA(1, 1);
    runA(100, 0);
`ifdef FRAME_CHECKSUM_EN
    check("t6_cs", csA, 32'h07F8);
`endif
    endFrameA("t6");
    stepA(1, 1);
`ifdef FRAME_CHECKSUM_EN
    check("t6_cs_clr", csA, 0);
`endif
    runA(60, 0);
    endFrameA("t7");

    // 3: 16x16 frame with 30% ready duty
    stepB(0, 1);
    for (int i = 0; i < 4000 && ndoneB == 0; i++)
      stepB($urandom_range(0, 99) < 30, 0);
    check("t3_done", ndoneB, 1);
    check("t3_xfers", kB, BP);
    check("t3_locks", lockB, BP);
    check("t3_busy", busyB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
